// File: rtl/dram_cmd_fsm_if.sv
// dram_cmd_fsm_if: request, timing-strobe and command bundle between a DRAM command sequencer and its environment
interface dram_cmd_fsm_if #(parameter int ROW_W = 16, parameter int BANK_W = 4);
  logic              init_done;
  logic              req_valid;
  logic              req_write;
  logic [BANK_W-1:0] req_bank;
  logic [ROW_W-1:0]  req_row;
  logic              req_ready;
  logic              req_done;
  logic              tACT_done;
  logic              tRD_done;
  logic              tWR_done;
  logic              tPRE_done;
  logic              tREF_done;
  logic              rf_req;
  logic              cmd_valid;
  logic [2:0]        cmd_code;
  logic [BANK_W-1:0] cmd_bank;
  logic [ROW_W-1:0]  cmd_row;
  logic              row_open;
  modport master (
    output init_done, req_valid, req_write, req_bank, req_row,
    output tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done, rf_req,
    input  req_ready, req_done, cmd_valid, cmd_code, cmd_bank, cmd_row, row_open
  );
  modport slave (
    input  init_done, req_valid, req_write, req_bank, req_row,
    input  tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done, rf_req,
    output req_ready, req_done, cmd_valid, cmd_code, cmd_bank, cmd_row, row_open
  );
endinterface

// File: rtl/dram_cmd_fsm.sv
// dram_cmd_fsm: open-page DRAM command sequencer; define CLOSED_PAGE_EN to precharge after every access
module dram_cmd_fsm #(
  parameter int ROW_W  = 16,
  parameter int BANK_W = 4
) (
  input logic          CLK,
  input logic          RST,
  dram_cmd_fsm_if.slave bus
);
  typedef enum logic [3:0] {
    INIT, READY, ACT_ISSUE, ACT_WAIT, RD_ISSUE, WR_ISSUE, RW_WAIT,
    PRE_ISSUE, PRE_WAIT, REF_ISSUE, REF_WAIT
  } state_t;
  typedef enum logic [1:0] {P_ACC, P_REF, P_CLOSE} path_t;
  state_t                   state_q, state_d;
  path_t                    path_q, path_d;
  logic [BANK_W-1:0]        bank_q, bank_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [BANK_W+ROW_W-1:0]  tag_q, tag_d;
  logic                     wr_q, wr_d;
  logic                     open_q, open_d;
  logic                     done_q, done_d;
  logic [2:0]               cmd_code_q, cmd_code_d;
  logic [BANK_W-1:0]        cmd_bank_q, cmd_bank_d;
  logic [ROW_W-1:0]         cmd_row_q, cmd_row_d;
  logic                     hit;
  assign hit = open_q && tag_q == {bus.req_bank, bus.req_row};
  always_comb begin
    state_d = state_q;
    path_d  = path_q;
    bank_d  = bank_q;
    row_d   = row_q;
    wr_d    = wr_q;
    tag_d   = tag_q;
    open_d  = open_q;
    done_d  = 1'b0;
    case (state_q)
      INIT:      state_d = bus.init_done ? READY : INIT;
      READY: begin
        if (bus.rf_req) begin
          path_d  = P_REF;
          state_d = open_q ? PRE_ISSUE : REF_ISSUE;
        end else if (bus.req_valid) begin
          bank_d  = bus.req_bank;
          row_d   = bus.req_row;
          wr_d    = bus.req_write;
          path_d  = P_ACC;
          state_d = !open_q ? ACT_ISSUE : hit ? (bus.req_write ? WR_ISSUE : RD_ISSUE) : PRE_ISSUE;
        end
      end
      ACT_ISSUE: state_d = ACT_WAIT;
      ACT_WAIT: begin
        if (bus.tACT_done) begin
          tag_d   = {bank_q, row_q};
          open_d  = 1'b1;
          state_d = wr_q ? WR_ISSUE : RD_ISSUE;
        end
      end
      RD_ISSUE:  state_d = RW_WAIT;
      WR_ISSUE:  state_d = RW_WAIT;
      RW_WAIT: begin
        if (wr_q ? bus.tWR_done : bus.tRD_done) begin
          done_d  = 1'b1;
`ifdef CLOSED_PAGE_EN
          path_d  = P_CLOSE;
          state_d = PRE_ISSUE;
`else
          state_d = READY;
`endif
        end
      end
      PRE_ISSUE: state_d = PRE_WAIT;
      PRE_WAIT: begin
        if (bus.tPRE_done) begin
          open_d  = 1'b0;
          state_d = path_q == P_REF ? REF_ISSUE : path_q == P_ACC ? ACT_ISSUE : READY;
        end
      end
      REF_ISSUE: state_d = REF_WAIT;
      REF_WAIT:  state_d = bus.tREF_done ? READY : REF_WAIT;
      default:   state_d = INIT;
    endcase
    // command fields are registered on entry to each issue state; PRE closes the currently open bank
    cmd_code_d = state_d == ACT_ISSUE ? 3'd1 : state_d == RD_ISSUE ? 3'd2 : state_d == WR_ISSUE ? 3'd3 :
                 state_d == PRE_ISSUE ? 3'd4 : state_d == REF_ISSUE ? 3'd5 : 3'd0;
    cmd_bank_d = state_d == PRE_ISSUE ? tag_q[ROW_W +: BANK_W] :
                 state_d inside {ACT_ISSUE, RD_ISSUE, WR_ISSUE} ? bank_d : '0;
    cmd_row_d  = state_d == ACT_ISSUE ? row_d : '0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= INIT;
      path_q     <= P_ACC;
      bank_q     <= '0;
      row_q      <= '0;
      wr_q       <= 1'b0;
      tag_q      <= '0;
      open_q     <= 1'b0;
      done_q     <= 1'b0;
      cmd_code_q <= 3'd0;
      cmd_bank_q <= '0;
      cmd_row_q  <= '0;
    end else begin
      state_q    <= state_d;
      path_q     <= path_d;
      bank_q     <= bank_d;
      row_q      <= row_d;
      wr_q       <= wr_d;
      tag_q      <= tag_d;
      open_q     <= open_d;
      done_q     <= done_d;
      cmd_code_q <= cmd_code_d;
      cmd_bank_q <= cmd_bank_d;
      cmd_row_q  <= cmd_row_d;
    end
  end
  assign bus.req_ready = state_q == READY && !bus.rf_req;
  assign bus.req_done  = done_q;
  assign bus.cmd_valid = |cmd_code_q;
  assign bus.cmd_code  = cmd_code_q;
  assign bus.cmd_bank  = cmd_bank_q;
  assign bus.cmd_row   = cmd_row_q;
  assign bus.row_open  = open_q;
endmodule

// File: doc/dram_cmd_fsm.md
Name: dram_cmd_fsm

Overview:
Per-channel DRAM command sequencer that consumes the timing controller's done/refresh strobes (cmd_fsm side of timing_signal_if). It accepts one read/write request at a time and issues ACT/RD/WR/PRE/REF commands under an open-page policy. Each command is pulsed on cmd_valid/cmd_code to the PHY and to the timing controller, which uses it to start the matching timing counter.

Parameters:
ROW_W, 16, row address width
BANK_W, 4, bank address width (bank+row concatenated form the page tag)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
init_done  in  1  DRAM init sequence complete; FSM leaves INIT only when high
req_valid  in  1  request present
req_write  in  1  1=write, 0=read
req_bank  in  BANK_W  target bank
req_row  in  ROW_W  target row
req_ready  out  1  FSM can accept a request this cycle
req_done  out  1  one-cycle pulse when the accepted access completes
tACT_done  in  1  tRCD elapsed after ACT
tRD_done  in  1  read burst complete
tWR_done  in  1  write burst plus tWR complete
tPRE_done  in  1  tRP elapsed after PRE
tREF_done  in  1  tRFC elapsed after REF
rf_req  in  1  refresh due (level, held until REF issued)
cmd_valid  out  1  one-cycle command strobe
cmd_code  out  3  NOP=0 ACT=1 RD=2 WR=3 PRE=4 REF=5
cmd_bank  out  BANK_W  bank for ACT/RD/WR/PRE
cmd_row  out  ROW_W  row for ACT
row_open  out  1  a page is currently open

Behaviour:
- Reset (RST high at CLK edge): state=INIT, all outputs 0, cmd_code=NOP, open-page tag cleared, row_open=0. Reset mid-operation aborts immediately; no PRE is issued.
- Commands are registered: cmd_valid high exactly one cycle on entry to each ACT/RD/WR/PRE/REF issue state. cmd_code=NOP whenever cmd_valid=0.
- States and transitions:
  - INIT -> READY when init_done=1.
  - READY: req_ready=1 iff rf_req=0.
    - rf_req=1 with row_open -> PRE_ISSUE (refresh path). rf_req=1 with no open row -> REF_ISSUE.
    - Otherwise, on req_valid&req_ready the request fields are latched:
      - hit (row_open and tag==req bank/row) -> RD_ISSUE/WR_ISSUE.
      - miss with row_open -> PRE_ISSUE (access path).
      - no open row -> ACT_ISSUE.
  - ACT_ISSUE (1 cycle) -> ACT_WAIT. On tACT_done: set tag, row_open=1, -> RD_ISSUE or WR_ISSUE.
  - RD_ISSUE/WR_ISSUE (1 cycle) -> RW_WAIT. On tRD_done (read) or tWR_done (write): req_done pulse, -> READY.
  - PRE_ISSUE (1 cycle) -> PRE_WAIT. On tPRE_done: row_open=0, then -> REF_ISSUE on the refresh path or ACT_ISSUE on the access path.
  - REF_ISSUE (1 cycle) -> REF_WAIT. On tREF_done -> READY.
- Simultaneous rf_req and req_valid in READY: refresh wins, request not accepted (req_ready=0).
- rf_req asserting during an access does not interrupt it; it is serviced on the next READY.
- Done strobes arriving outside their matching wait state are ignored.
- Minimum latency, row hit read: accept at cycle 0, RD strobe at cycle 1, req_done one cycle after tRD_done.

Optional Feature:
CLOSED_PAGE_EN.
- Defined: after each RW_WAIT completion the FSM goes to PRE_ISSUE and then READY, so every access is ACT...PRE. req_done still pulses on tRD_done/tWR_done. row_open is 0 whenever the FSM is in READY, so hits never occur.
- Undefined: open-page policy as described above.

Test Plan:
- Reset/init: RST=1 for 2 cycles, init_done=0 -> req_ready=0 and cmd_valid=0. init_done=1 -> req_ready=1 next cycle.
- Cold read bank 2 row 0x0010 -> ACT (cmd_code=1, bank 2, row 0x0010). After tACT_done -> RD (code 2). After tRD_done -> req_done pulse, row_open=1.
- Row-hit write to bank 2 row 0x0010 -> WR (code 3) issued at cycle 1 with no ACT. tWR_done -> req_done.
- Row miss to bank 2 row 0x0020 -> PRE, then tPRE_done -> ACT row 0x0020, then RD. Exactly three cmd_valid pulses.
- rf_req=1 and req_valid=1 in the same cycle with a row open -> req_ready=0, PRE then REF (code 5). After tREF_done the request is accepted and issues ACT.
- Spurious tACT_done/tPRE_done pulses in READY -> no state change and no cmd_valid. RST asserted in ACT_WAIT -> INIT next cycle with outputs zero.
